// File: rtl/uart_core_if.sv
//------------------------------------------------------------------------------
// uart_core_if : byte-stream handshakes between uart_core and its host.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_core_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;
  logic [LW-1:0]        tx_level;
  logic [LW-1:0]        rx_level;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err,
           rx_overrun, tx_level, rx_level
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err,
           rx_overrun, tx_level, rx_level
  );
endinterface

`default_nettype wire

// File: rtl/uart_core.sv
//------------------------------------------------------------------------------
// uart_core : full-duplex UART with FWFT TX/RX FIFOs and per-byte error flags.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_core #(
  parameter int CLK_DIV    = 234,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  uart_core_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_DIV * STOP_BITS + 1);
  localparam int IW = $clog2(DATA_BITS);
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] c_BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] c_STOP_END = CW'(CLK_DIV * STOP_BITS - 1);
  localparam logic [CW-1:0] c_HALF     = CW'(CLK_DIV / 2);
  localparam logic [IW-1:0] c_LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [LW-1:0] c_FULL     = LW'(FIFO_DEPTH);
  localparam logic          c_HAS_PAR  = (PARITY != 0);
  localparam logic          c_ODD      = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] r_txMem [FIFO_DEPTH];
  logic [AW-1:0]        r_txWr, r_txRd;
  logic [LW-1:0]        r_txLevel;
  logic                 w_txPush, w_txPop, w_txAvail;

  assign w_txPush  = bus.tx_valid && (r_txLevel != c_FULL);
  assign w_txAvail = (r_txLevel != '0);

  always_ff @(posedge clk) begin
    if (w_txPush) r_txMem[r_txWr] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txWr    <= '0;
      r_txRd    <= '0;
      r_txLevel <= '0;
    end else begin
      if (w_txPush) r_txWr <= r_txWr + 1'b1;
      if (w_txPop)  r_txRd <= r_txRd + 1'b1;
      r_txLevel <= r_txLevel + LW'(w_txPush) - LW'(w_txPop);
    end
  end

  // ---------------- TX FSM ----------------
  state_t               r_txState, w_txStateNext;
  logic [CW-1:0]        r_txCnt, w_txCntNext;
  logic [IW-1:0]        r_txIdx, w_txIdxNext;
  logic [DATA_BITS-1:0] r_txShift;
  logic                 r_txPar, r_txLine, w_txLineNext;

  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt + 1'b1;
    w_txIdxNext   = r_txIdx;
    w_txPop       = 1'b0;
    w_txLineNext  = 1'b1;
    unique case (r_txState)
      S_IDLE: begin
        w_txCntNext = '0;
        if (w_txAvail) begin
          w_txPop       = 1'b1;
          w_txStateNext = S_START;
        end
      end
      S_START: begin
        w_txLineNext = 1'b0;
        if (r_txCnt == c_BIT_END) begin
          w_txCntNext   = '0;
          w_txIdxNext   = '0;
          w_txStateNext = S_DATA;
        end
      end
      S_DATA: begin
        w_txLineNext = r_txShift[r_txIdx];
        if (r_txCnt == c_BIT_END) begin
          w_txCntNext = '0;
          if (r_txIdx == c_LAST_BIT) w_txStateNext = c_HAS_PAR ? S_PARITY : S_STOP;
          else                       w_txIdxNext   = r_txIdx + 1'b1;
        end
      end
      S_PARITY: begin
        w_txLineNext = r_txPar;
        if (r_txCnt == c_BIT_END) begin
          w_txCntNext   = '0;
          w_txStateNext = S_STOP;
        end
      end
      S_STOP: begin
        // Chain straight into the next START so queued bytes go out gap-free.
        if (r_txCnt == c_STOP_END) begin
          w_txCntNext = '0;
          if (w_txAvail) begin
            w_txPop       = 1'b1;
            w_txStateNext = S_START;
          end else begin
            w_txStateNext = S_IDLE;
          end
        end
      end
      default: w_txStateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txState <= S_IDLE;
      r_txCnt   <= '0;
      r_txIdx   <= '0;
      r_txShift <= '0;
      r_txPar   <= 1'b0;
      r_txLine  <= 1'b1;
    end else begin
      r_txState <= w_txStateNext;
      r_txCnt   <= w_txCntNext;
      r_txIdx   <= w_txIdxNext;
      r_txLine  <= w_txLineNext;
      if (w_txPop) begin
        r_txShift <= r_txMem[r_txRd];
        r_txPar   <= (^r_txMem[r_txRd]) ^ c_ODD;
      end
    end
  end

  assign uart_tx = r_txLine;

  // ---------------- RX FSM ----------------
  state_t               r_rxState, w_rxStateNext;
  logic [CW-1:0]        r_rxCnt, w_rxCntNext;
  logic [IW-1:0]        r_rxIdx, w_rxIdxNext;
  logic [DATA_BITS-1:0] r_rxShift;
  logic                 r_rxMeta, r_rxSync, r_rxParBit, r_rxArmed;
  logic                 r_rxPush, r_rxOverrun;
  logic [EW-1:0]        r_rxEntry;
  logic                 w_takeBit, w_takePar, w_takeStop, w_rxParErr;

  assign w_rxParErr = c_HAS_PAR && (r_rxParBit != ((^r_rxShift) ^ c_ODD));

  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxCntNext   = r_rxCnt + 1'b1;
    w_rxIdxNext   = r_rxIdx;
    w_takeBit     = 1'b0;
    w_takePar     = 1'b0;
    w_takeStop    = 1'b0;
    unique case (r_rxState)
      S_IDLE: begin
        w_rxCntNext = CW'(1);
        if (!r_rxSync && r_rxArmed) w_rxStateNext = S_START;
      end
      S_START: begin
        if (r_rxCnt == c_HALF) begin
          w_rxCntNext   = '0;
          w_rxIdxNext   = '0;
          w_rxStateNext = r_rxSync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_rxCnt == c_BIT_END) begin
          w_rxCntNext = '0;
          w_takeBit   = 1'b1;
          if (r_rxIdx == c_LAST_BIT) w_rxStateNext = c_HAS_PAR ? S_PARITY : S_STOP;
          else                       w_rxIdxNext   = r_rxIdx + 1'b1;
        end
      end
      S_PARITY: begin
        if (r_rxCnt == c_BIT_END) begin
          w_rxCntNext   = '0;
          w_takePar     = 1'b1;
          w_rxStateNext = S_STOP;
        end
      end
      S_STOP: begin
        if (r_rxCnt == c_BIT_END) begin
          w_takeStop    = 1'b1;
          w_rxStateNext = S_IDLE;
        end
      end
      default: w_rxStateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxMeta   <= 1'b1;
      r_rxSync   <= 1'b1;
      r_rxState  <= S_IDLE;
      r_rxCnt    <= '0;
      r_rxIdx    <= '0;
      r_rxShift  <= '0;
      r_rxParBit <= 1'b0;
      r_rxArmed  <= 1'b1;
      r_rxPush   <= 1'b0;
      r_rxEntry  <= '0;
    end else begin
      r_rxMeta  <= uart_rx;
      r_rxSync  <= r_rxMeta;
      r_rxState <= w_rxStateNext;
      r_rxCnt   <= w_rxCntNext;
      r_rxIdx   <= w_rxIdxNext;
      r_rxPush  <= w_takeStop;
      if (w_takeBit) r_rxShift  <= {r_rxSync, r_rxShift[DATA_BITS-1:1]};
      if (w_takePar) r_rxParBit <= r_rxSync;
      if (w_takeStop) r_rxEntry <= {w_rxParErr, ~r_rxSync, r_rxShift};
      // A low stop bit disarms start detection until the line idles high,
      // so a held break produces a single entry.
      if (w_takeStop && !r_rxSync) r_rxArmed <= 1'b0;
      else if (r_rxSync)           r_rxArmed <= 1'b1;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [EW-1:0] r_rxMem [FIFO_DEPTH];
  logic [AW-1:0] r_rxWr, r_rxRd;
  logic [LW-1:0] r_rxLevel;
  logic          w_rxPop, w_rxWrite, w_rxFull;
  logic [EW-1:0] w_rxHead;

  assign w_rxFull  = (r_rxLevel == c_FULL);
  assign w_rxPop   = (r_rxLevel != '0) && bus.rx_ready;
  assign w_rxWrite = r_rxPush && (!w_rxFull || w_rxPop);
  assign w_rxHead  = bus.rx_valid ? r_rxMem[r_rxRd] : '0;

  always_ff @(posedge clk) begin
    if (w_rxWrite) r_rxMem[r_rxWr] <= r_rxEntry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxWr      <= '0;
      r_rxRd      <= '0;
      r_rxLevel   <= '0;
      r_rxOverrun <= 1'b0;
    end else begin
      if (w_rxWrite) r_rxWr <= r_rxWr + 1'b1;
      if (w_rxPop)   r_rxRd <= r_rxRd + 1'b1;
      r_rxLevel   <= r_rxLevel + LW'(w_rxWrite) - LW'(w_rxPop);
      r_rxOverrun <= r_rxPush && w_rxFull && !w_rxPop;
    end
  end

  assign bus.tx_ready      = (r_txLevel != c_FULL);
  assign bus.tx_level      = r_txLevel;
  assign bus.rx_valid      = (r_rxLevel != '0);
  assign bus.rx_level      = r_rxLevel;
  assign bus.rx_data       = w_rxHead[DATA_BITS-1:0];
  assign bus.rx_frame_err  = w_rxHead[DATA_BITS];
  assign bus.rx_parity_err = w_rxHead[DATA_BITS+1];
  assign bus.rx_overrun    = r_rxOverrun;
endmodule

`default_nettype wire

// File: tb/tb_uart_core.sv
//------------------------------------------------------------------------------
// tb_uart_core : checks an 8N1 loopback instance and a 7E2 instance.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_core;
  localparam int A_CD = 234, A_DB = 8, A_PAR = 0, A_SB = 1, A_DEPTH = 16;
  localparam int B_CD = 16,  B_DB = 7, B_PAR = 2, B_SB = 2, B_DEPTH = 4;
  localparam int B_FRAME = B_CD * (1 + B_DB + 1 + B_SB);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA_n, rstB_n, loopA, drvA, drvB;
  wire  txA, txB, rxA, rxB;
  assign rxA = loopA ? txA : drvA;
  assign rxB = drvB;

  uart_core_if #(.DATA_BITS(A_DB), .FIFO_DEPTH(A_DEPTH)) bifA ();
  uart_core_if #(.DATA_BITS(B_DB), .FIFO_DEPTH(B_DEPTH)) bifB ();

  uart_core #(.CLK_DIV(A_CD), .DATA_BITS(A_DB), .PARITY(A_PAR), .STOP_BITS(A_SB),
              .FIFO_DEPTH(A_DEPTH))
    dutA (.clk(clk), .rst_n(rstA_n), .uart_rx(rxA), .uart_tx(txA), .bus(bifA.slave));
  uart_core #(.CLK_DIV(B_CD), .DATA_BITS(B_DB), .PARITY(B_PAR), .STOP_BITS(B_SB),
              .FIFO_DEPTH(B_DEPTH))
    dutB (.clk(clk), .rst_n(rstB_n), .uart_rx(rxB), .uart_tx(txB), .bus(bifB.slave));

  int cyc = 0, tests = 0, fails = 0, ovrB = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rstB_n && bifB.rx_overrun) ovrB <= ovrB + 1;

  // ---------------- helpers (stimulus / observation only) ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) wait_cyc(1);
  endtask

  function automatic logic tx_line(input bit w);
    return w ? txB : txA;
  endfunction

  // Reference: even parity bit for the 7E2 format is the count of ones mod 2.
  function automatic logic b_parity(input logic [6:0] d);
    return logic'($countones(d) % 2);
  endfunction

  task automatic push(input bit w, input logic [7:0] d);
    if (w) begin bifB.tx_data = d[6:0]; bifB.tx_valid = 1'b1; end
    else   begin bifA.tx_data = d;      bifA.tx_valid = 1'b1; end
    wait_cyc(1);
    bifA.tx_valid = 1'b0;
    bifB.tx_valid = 1'b0;
  endtask

  task automatic pop(input bit w);
    if (w) bifB.rx_ready = 1'b1; else bifA.rx_ready = 1'b1;
    wait_cyc(1);
    bifA.rx_ready = 1'b0;
    bifB.rx_ready = 1'b0;
  endtask

  task automatic find_start(input bit w, input int limit, output int s, output bit ok);
    ok = 1'b0;
    s  = cyc;
    for (int i = 0; i < limit && !ok; i++) begin
      if (tx_line(w) == 1'b0) begin ok = 1'b1; s = cyc; end
      else wait_cyc(1);
    end
  endtask

  // Samples the TX line at the middle of every bit of a frame starting at s.
  task automatic decode_tx(input bit w, input int s, output logic [7:0] d,
                           output logic pb, output logic [1:0] stops);
    int cd, nb, hp, sb;
    cd = w ? B_CD : A_CD;
    nb = w ? B_DB : A_DB;
    hp = ((w ? B_PAR : A_PAR) != 0) ? 1 : 0;
    sb = w ? B_SB : A_SB;
    d = '0; pb = 1'b0; stops = '0;
    for (int i = 0; i < nb; i++) begin
      wait_until(s + cd * (1 + i) + cd / 2);
      d[i] = tx_line(w);
    end
    if (hp != 0) begin
      wait_until(s + cd * (1 + nb) + cd / 2);
      pb = tx_line(w);
    end
    for (int i = 0; i < sb; i++) begin
      wait_until(s + cd * (1 + nb + hp + i) + cd / 2);
      stops[i] = tx_line(w);
    end
  endtask

  // Drives one 7E2 frame on B's serial input, optionally corrupted.
  task automatic drive_frame_b(input logic [6:0] d, input bit pflip, input bit stopLow);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < B_DB; i++) bits.push_back(d[i]);
    bits.push_back(b_parity(d) ^ pflip);
    bits.push_back(~stopLow);
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      drvB = bits[i];
      wait_cyc(B_CD);
    end
    drvB = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rstA_n = 1'b0; rstB_n = 1'b0;
    wait_cyc(3);
    tests++; if (txA !== 1'b1) begin $display("FAIL reset_tx_idle: got %b want 1", txA); fails++; end
    tests++; if (bifA.tx_ready !== 1'b1) begin $display("FAIL reset_tx_ready: got %b want 1", bifA.tx_ready); fails++; end
    tests++; if (bifA.rx_valid !== 1'b0) begin $display("FAIL reset_rx_valid: got %b want 0", bifA.rx_valid); fails++; end
    tests++; if ({bifA.tx_level, bifA.rx_level} !== '0) begin
      $display("FAIL reset_levels: got tx=%0d rx=%0d want 0/0", bifA.tx_level, bifA.rx_level); fails++; end
    rstA_n = 1'b1; rstB_n = 1'b1;
    wait_cyc(3);
    tests++; if (txB !== 1'b1) begin $display("FAIL post_reset_tx: got %b want 1", txB); fails++; end
    tests++; if ({bifB.rx_data, bifB.rx_frame_err, bifB.rx_parity_err, bifB.rx_overrun} !== '0) begin
      $display("FAIL post_reset_rx_head: got data=%h fe=%b pe=%b ov=%b want zeros", bifB.rx_data,
               bifB.rx_frame_err, bifB.rx_parity_err, bifB.rx_overrun); fails++; end
    tests++; if (bifB.tx_ready !== 1'b1 || bifB.tx_level !== '0 || bifB.rx_level !== '0) begin
      $display("FAIL post_reset_fifo: got rdy=%b txl=%0d rxl=%0d want 1/0/0", bifB.tx_ready,
               bifB.tx_level, bifB.rx_level); fails++; end
  endtask

  task automatic test_loopback;
    logic [7:0] exp [3];
    logic [7:0] d;
    logic pb;
    logic [1:0] st;
    int s, s0;
    bit ok;
    exp[0] = 8'h55; exp[1] = 8'hA3; exp[2] = 8'h00;
    push(1'b0, exp[0]);
    push(1'b0, exp[1]);
    tests++; if (txA !== 1'b1) begin $display("FAIL tx_latency_early: got %b want 1", txA); fails++; end
    push(1'b0, exp[2]);
    tests++; if (txA !== 1'b0) begin $display("FAIL tx_latency_2: got %b want 0", txA); fails++; end
    find_start(1'b0, 10, s0, ok);
    for (int k = 0; k < 3; k++) begin
      s = s0 + A_CD * 10 * k;
      if (k > 0) begin
        wait_until(s - 1);
        tests++; if (txA !== 1'b1) begin $display("FAIL lb_stop_end%0d: got %b want 1", k, txA); fails++; end
        wait_until(s);
        tests++; if (txA !== 1'b0) begin $display("FAIL lb_frame_len%0d: got %b want 0 at 2340", k, txA); fails++; end
      end
      decode_tx(1'b0, s, d, pb, st);
      tests++; if (d !== exp[k] || st !== 2'b01) begin
        $display("FAIL lb_tx_byte%0d: got %h stop=%b want %h stop=01", k, d, st, exp[k]); fails++; end
    end
    wait_cyc(A_CD);
    tests++; if (bifA.rx_level !== 5'd3) begin $display("FAIL lb_rx_level: got %0d want 3", bifA.rx_level); fails++; end
    for (int k = 0; k < 3; k++) begin
      tests++; if ({bifA.rx_valid, bifA.rx_parity_err, bifA.rx_frame_err, bifA.rx_data} !== {3'b100, exp[k]}) begin
        $display("FAIL lb_rx_byte%0d: got v=%b pe=%b fe=%b %h want 1/0/0 %h", k, bifA.rx_valid,
                 bifA.rx_parity_err, bifA.rx_frame_err, bifA.rx_data, exp[k]); fails++; end
      pop(1'b0);
    end
    tests++; if (bifA.rx_valid !== 1'b0) begin $display("FAIL lb_rx_empty: got %b want 0", bifA.rx_valid); fails++; end
  endtask

  task automatic test_7e2_tx;
    logic [6:0] r;
    logic [7:0] d;
    logic pb;
    logic [1:0] st;
    int s;
    bit ok;
    r = 7'($urandom_range(0, 127));
    push(1'b1, 8'h41);
    push(1'b1, {1'b0, r});
    find_start(1'b1, 10, s, ok);
    tests++; if (!ok) begin $display("FAIL 7e2_start: got none want falling edge"); fails++; end
    decode_tx(1'b1, s, d, pb, st);
    tests++; if ({d, pb, st} !== {8'h41, 1'b0, 2'b11}) begin
      $display("FAIL 7e2_frame: got %h p=%b stop=%b want 41 p=0 stop=11", d, pb, st); fails++; end
    wait_until(s + B_FRAME - 1);
    tests++; if (txB !== 1'b1) begin $display("FAIL 7e2_stop2: got %b want 1", txB); fails++; end
    wait_until(s + B_FRAME);
    tests++; if (txB !== 1'b0) begin $display("FAIL 7e2_frame_len: got %b want 0", txB); fails++; end
    decode_tx(1'b1, s + B_FRAME, d, pb, st);
    tests++; if ({d, pb, st} !== {1'b0, r, b_parity(r), 2'b11}) begin
      $display("FAIL 7e2_rand_frame: got %h p=%b st=%b want %h p=%b st=11", d, pb, st, r, b_parity(r)); fails++; end
  endtask

  task automatic test_7e2_rx;
    int e0;
    e0 = cyc;
    fork
      drive_frame_b(7'h41, 1'b1, 1'b0);
      begin
        wait_until(e0 + 3 + B_CD / 2 + B_CD * (B_DB + 2));
        tests++; if (bifB.rx_valid !== 1'b0) begin $display("FAIL rx_latency_early: got %b want 0", bifB.rx_valid); fails++; end
        wait_until(e0 + 6 + B_CD / 2 + B_CD * (B_DB + 2));
        tests++; if (bifB.rx_valid !== 1'b1) begin $display("FAIL rx_latency_late: got %b want 1", bifB.rx_valid); fails++; end
      end
    join
    tests++; if ({bifB.rx_parity_err, bifB.rx_frame_err, bifB.rx_data} !== {2'b10, 7'h41}) begin
      $display("FAIL rx_parity_err: got pe=%b fe=%b %h want 1/0 41", bifB.rx_parity_err,
               bifB.rx_frame_err, bifB.rx_data); fails++; end
    pop(1'b1);
  endtask

  task automatic test_framing_break;
    drive_frame_b(7'h3C, 1'b0, 1'b1);
    wait_cyc(4);
    tests++; if ({bifB.rx_valid, bifB.rx_parity_err, bifB.rx_frame_err, bifB.rx_data} !== {3'b101, 7'h3C}) begin
      $display("FAIL frame_err: got v=%b pe=%b fe=%b %h want 1/0/1 3c", bifB.rx_valid,
               bifB.rx_parity_err, bifB.rx_frame_err, bifB.rx_data); fails++; end
    pop(1'b1);
    drvB = 1'b0;
    wait_cyc(3 * B_FRAME);
    drvB = 1'b1;
    wait_cyc(3 * B_CD);
    tests++; if (bifB.rx_level !== 3'd1) begin $display("FAIL break_count: got %0d want 1", bifB.rx_level); fails++; end
    tests++; if ({bifB.rx_parity_err, bifB.rx_frame_err, bifB.rx_data} !== {2'b01, 7'h00}) begin
      $display("FAIL break_entry: got pe=%b fe=%b %h want 0/1 00", bifB.rx_parity_err,
               bifB.rx_frame_err, bifB.rx_data); fails++; end
    pop(1'b1);
  endtask

  task automatic test_false_start;
    logic [6:0] r;
    drvB = 1'b0;
    wait_cyc(B_CD / 4);
    drvB = 1'b1;
    wait_cyc(3 * B_CD);
    tests++; if (bifB.rx_level !== 3'd0) begin $display("FAIL false_start_push: got %0d want 0", bifB.rx_level); fails++; end
    r = 7'($urandom_range(0, 127));
    drive_frame_b(r, 1'b0, 1'b0);
    wait_cyc(4);
    tests++; if ({bifB.rx_level, bifB.rx_parity_err, bifB.rx_frame_err, bifB.rx_data} !== {3'd1, 2'b00, r}) begin
      $display("FAIL false_start_recover: got l=%0d pe=%b fe=%b %h want 1/0/0 %h", bifB.rx_level,
               bifB.rx_parity_err, bifB.rx_frame_err, bifB.rx_data, r); fails++; end
    pop(1'b1);
  endtask

  task automatic test_random_rx;
    logic [6:0] d;
    bit pf, sl;
    for (int i = 0; i < 6; i++) begin
      d  = 7'($urandom_range(0, 127));
      pf = ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 3) == 0);
      drive_frame_b(d, pf, sl);
      wait_cyc(4);
      tests++; if ({bifB.rx_level, bifB.rx_parity_err, bifB.rx_frame_err, bifB.rx_data} !== {3'd1, pf, sl, d}) begin
        $display("FAIL rand_rx%0d: got l=%0d pe=%b fe=%b %h want 1/%b/%b %h", i, bifB.rx_level,
                 bifB.rx_parity_err, bifB.rx_frame_err, bifB.rx_data, pf, sl, d); fails++; end
      pop(1'b1);
    end
  endtask

  task automatic test_overrun;
    logic [6:0] q [$];
    int ov0, e0;
    ov0 = ovrB;
    for (int i = 0; i <= B_DEPTH; i++) q.push_back(7'($urandom_range(0, 127)));
    foreach (q[i]) drive_frame_b(q[i], 1'b0, 1'b0);
    wait_cyc(4);
    tests++; if (bifB.rx_level !== 3'(B_DEPTH)) begin $display("FAIL ovr_level: got %0d want %0d", bifB.rx_level, B_DEPTH); fails++; end
    tests++; if (ovrB - ov0 !== 1) begin $display("FAIL ovr_pulse: got %0d want 1", ovrB - ov0); fails++; end
    for (int i = 0; i < B_DEPTH; i++) begin
      tests++; if (bifB.rx_data !== q[i]) begin $display("FAIL ovr_keep%0d: got %h want %h", i, bifB.rx_data, q[i]); fails++; end
      pop(1'b1);
    end
    // Second pass: a pop lands in the same cycle as the overflowing push.
    q.delete();
    ov0 = ovrB;
    for (int i = 0; i <= B_DEPTH; i++) q.push_back(7'($urandom_range(0, 127)));
    for (int i = 0; i < B_DEPTH; i++) drive_frame_b(q[i], 1'b0, 1'b0);
    e0 = cyc;
    fork
      drive_frame_b(q[B_DEPTH], 1'b0, 1'b0);
      begin
        wait_until(e0 + 3 + B_CD / 2 + B_CD * (B_DB + 2));
        tests++; if (bifB.rx_data !== q[0]) begin $display("FAIL ovr_pop_head: got %h want %h", bifB.rx_data, q[0]); fails++; end
        pop(1'b1);
      end
    join
    wait_cyc(4);
    tests++; if (ovrB - ov0 !== 0) begin $display("FAIL ovr_simul_pulse: got %0d want 0", ovrB - ov0); fails++; end
    tests++; if (bifB.rx_level !== 3'(B_DEPTH)) begin $display("FAIL ovr_simul_level: got %0d want %0d", bifB.rx_level, B_DEPTH); fails++; end
    for (int i = 1; i <= B_DEPTH; i++) begin
      tests++; if (bifB.rx_data !== q[i]) begin $display("FAIL ovr_simul_keep%0d: got %h want %h", i, bifB.rx_data, q[i]); fails++; end
      pop(1'b1);
    end
  endtask

  task automatic test_reset_mid;
    logic [6:0] r;
    logic [7:0] d;
    logic pb;
    logic [1:0] st;
    int s;
    bit ok;
    r = 7'($urandom_range(0, 127)) & 7'h77;
    push(1'b1, {1'b0, r});
    push(1'b1, 8'h2A);
    find_start(1'b1, 10, s, ok);
    wait_until(s + B_CD * 4 + B_CD / 2);
    tests++; if (txB !== 1'b0) begin $display("FAIL mid_bit3: got %b want 0", txB); fails++; end
    rstB_n = 1'b0;
    #1;
    tests++; if (txB !== 1'b1) begin $display("FAIL mid_reset_tx: got %b want 1", txB); fails++; end
    tests++; if (bifB.tx_level !== '0 || bifB.rx_level !== '0 || bifB.tx_ready !== 1'b1) begin
      $display("FAIL mid_reset_fifo: got txl=%0d rxl=%0d rdy=%b want 0/0/1", bifB.tx_level,
               bifB.rx_level, bifB.tx_ready); fails++; end
    wait_cyc(3);
    rstB_n = 1'b1;
    wait_cyc(2);
    r = 7'($urandom_range(0, 127));
    push(1'b1, {1'b0, r});
    find_start(1'b1, 10, s, ok);
    decode_tx(1'b1, s, d, pb, st);
    tests++; if (!ok || {d, pb, st} !== {1'b0, r, b_parity(r), 2'b11}) begin
      $display("FAIL mid_after_reset: got ok=%b %h p=%b st=%b want %h p=%b st=11", ok, d, pb, st, r, b_parity(r)); fails++; end
  endtask

  initial begin
    rstA_n = 1'b1; rstB_n = 1'b1; loopA = 1'b1; drvA = 1'b1; drvB = 1'b1;
    bifA.tx_data = '0; bifA.tx_valid = 1'b0; bifA.rx_ready = 1'b0;
    bifB.tx_data = '0; bifB.tx_valid = 1'b0; bifB.rx_ready = 1'b0;
    #2;
    test_reset();
    test_loopback();
    test_7e2_tx();
    test_7e2_rx();
    test_framing_break();
    test_false_start();
    test_random_rx();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART core: the next generation of the board's host serial link. Configurable frame format (data bits, parity, stop bits) and bit period. Independent RX and TX FIFOs behind valid/ready byte streams. Framing, parity and overrun errors are flagged per byte. Sits between the board UART pins and the host command decoder, and replaces the fixed 8N1, unbuffered serial front end.

## Interface
- `CLK_DIV`, default 234: clock cycles per bit (27 MHz / 115200). Must be ≥ 8.
- `DATA_BITS`, default 8: data bits per frame, 5..8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 16: entries per FIFO, power of two, ≥ 2.
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `uart_rx`  in  1: serial input, asynchronous to `clk`.
- `uart_tx`  out  1: serial output, idle high.
- `tx_data`  in  DATA_BITS: byte to transmit.
- `tx_valid`  in  1: `tx_data` is valid.
- `tx_ready`  out  1: TX FIFO not full.
- `rx_data`  out  DATA_BITS: head of the RX FIFO.
- `rx_valid`  out  1: RX FIFO not empty.
- `rx_ready`  in  1: consumer pops the head.
- `rx_frame_err`  out  1: head byte had its first stop bit sampled low.
- `rx_parity_err`  out  1: head byte failed the parity check. Always 0 when PARITY = 0.
- `rx_overrun`  out  1: one-cycle pulse when a received byte is dropped because the RX FIFO is full.
- `tx_level`  out  $clog2(FIFO_DEPTH)+1: TX FIFO occupancy.
- `rx_level`  out  $clog2(FIFO_DEPTH)+1: RX FIFO occupancy.

## Operation
- **Reset.** `rst_n` low clears both FIFOs, both FSMs and all counters. During reset and after it: `uart_tx` = 1, `tx_ready` = 1, `rx_valid` = 0, `rx_overrun` = 0, levels = 0. `rx_data` and the error flags read 0 while the FIFO is empty. Reset mid-frame aborts the frame immediately; `uart_tx` returns high asynchronously.
- **FIFOs.** First-word-fall-through, one per direction.
  - TX push: `tx_valid && tx_ready`.
  - RX pop: `rx_valid && rx_ready`.
  - RX entry layout: {parity_err, frame_err, data}.
  - Level arithmetic wraps nothing; level saturates structurally at FIFO_DEPTH.
- **TX FSM.** States IDLE → START → DATA → PARITY (skipped if PARITY = 0) → STOP → IDLE.
  - In IDLE with the FIFO non-empty: pop and enter START on the same edge.
  - Each state holds `uart_tx` for CLK_DIV cycles, or CLK_DIV × STOP_BITS for STOP.
  - Data bits go out LSB first. The parity bit is the XOR of the data bits, inverted for odd parity.
  - No inter-frame gap: if the FIFO is non-empty at the end of STOP, the next START follows directly.
- **RX synchroniser.** Two flops on `uart_rx`. All RX logic uses the synchronised value.
- **RX FSM.** States IDLE → START → DATA → PARITY (if enabled) → STOP → IDLE.
  - IDLE: a synchronised 0 enters START with counter = 1.
  - START: at counter = CLK_DIV/2, resample. If 1, it is a false start: return to IDLE with nothing pushed. If 0, proceed.
  - After START, every later bit is sampled once, CLK_DIV cycles after the previous sample (mid-bit).
  - Only the first stop bit is checked; a 0 sets frame_err.
  - After the stop sample, push the entry and return to IDLE directly. There is no wait for the end of the stop bit, so back-to-back frames resynchronise on the next falling edge.
  - With a frame error the byte is still pushed, with frame_err = 1. A break (line held low) therefore yields one errored entry of all zeros, then the FSM waits in IDLE→START cycles, which restart only after the line returns high and falls again.
- **Overrun.** A push into a full RX FIFO drops the new byte and pulses `rx_overrun`. If a pop happens in the same cycle as the push into a full FIFO, the pop takes effect first, the push is accepted, and there is no overrun.

## Timing
- TX latency: a push into the empty FIFO while in IDLE produces the `uart_tx` falling edge 2 cycles later (one cycle to register the pop and state, one to drive the output register).
- Frame length on `uart_tx`: CLK_DIV × (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) cycles.
- RX latency: `rx_valid` rises 2 cycles after the stop-bit sample edge (one cycle for the push, one for the level/flag update). The stop-bit sample edge is at 2 + CLK_DIV/2 + CLK_DIV × (DATA_BITS + (PARITY ≠ 0) + 1) cycles after the `uart_rx` falling edge, ±1.
- `tx_ready` drops in the cycle after the push that fills the FIFO. `rx_valid` drops in the cycle after the pop that empties it.
- Simultaneous push and pop on a non-full, non-empty FIFO: the level is unchanged.

## Test plan
- **Default 8N1 loopback.** Tie `uart_tx` to `uart_rx` and push 0x55, 0xA3, 0x00. Required: the RX pops the same three bytes in order with no error flags, and each TX frame is 2340 cycles.
- **7E2 format** (DATA_BITS = 7, PARITY = 2, STOP_BITS = 2). Push 0x41. Required: the line carries start, 1000001 (LSB first), parity 0, then 2 high stop bits. Drive 0x41 in with parity 1: the RX pops 0x41 with `rx_parity_err` = 1.
- **Framing and break.** Drive a 0x3C frame with its stop bit low: the RX pops 0x3C with `rx_frame_err` = 1. Hold the line low for 3 frames: exactly one entry of 0x00 with `rx_frame_err` = 1.
- **False start.** Drive a low glitch of CLK_DIV/4 cycles. Required: no push, and the FSM is back in IDLE.
- **Overrun.** Hold `rx_ready` = 0 and send FIFO_DEPTH + 1 bytes. Required: `rx_level` = FIFO_DEPTH, one `rx_overrun` pulse, and the first FIFO_DEPTH bytes are retained. Repeat with a pop coinciding with the push that would overflow: no overrun.
- **Reset mid-frame.** Assert `rst_n` low during TX bit 3. Required: `uart_tx` goes high immediately, levels are 0, and after release a new push transmits correctly.
